id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the register file.
- Captures rsData/rtData, the decoded instruction fields and the control bundle on each rising Clock edge.
- Detects load-use hazards and inserts a one-cycle bubble, asserting HazardStall so the PC and IF/ID hold.
- Handles branch flush, external pipeline hold and a saturating bubble counter.

Parameters:
- DATA_W, 32, width of operands, PC and immediate
- CNT_W, 16, width of the bubble statistics counter

Ports:
- Clock  in  1  pipeline clock; this block captures on posedge, the register file writes on negedge
- Reset  in  1  asynchronous, active-high; clears all state
- InstrIn  in  32  instruction from IF/ID
- PcPlus4In  in  DATA_W  PC+4 from IF/ID
- ValidIn  in  1  IF/ID slot holds a real instruction
- RsDataIn  in  DATA_W  register file rsData
- RtDataIn  in  DATA_W  register file rtData
- CtrlIn  in  10  {RegWrite, MemRead, MemWrite, MemToReg, AluSrc, RegDst, AluOp[3:0]} from decoder
- Flush  in  1  branch/jump resolved taken in EX; squash the slot being loaded
- ExtStall  in  1  downstream hold (e.g. memory busy)
- WbRegWrite  in  1  WB-stage write enable (used only with bypass)
- WbRd  in  5  WB destination register
- WbData  in  DATA_W  WB result
- HazardStall  out  1  combinational load-use stall to PC / IF/ID
- ValidOut  out  1  EX slot valid
- CtrlOut  out  10  registered control bundle
- PcPlus4Out  out  DATA_W  registered PC+4
- RsDataOut  out  DATA_W  registered rs operand
- RtDataOut  out  DATA_W  registered rt operand
- ImmOut  out  DATA_W  sign-extended InstrIn[15:0]
- RsOut  out  5  InstrIn[25:21]
- RtOut  out  5  InstrIn[20:16]
- RdOut  out  5  InstrIn[15:11]
- ShamtOut  out  5  InstrIn[10:6]
- BubbleCount  out  CNT_W  number of bubbles inserted

Behaviour:
- Reset (async, any time, including mid-stall): every output register goes to 0, BubbleCount goes to 0, ValidOut is 0, HazardStall evaluates to 0.
- Decode of MemRead: MemReadOut = CtrlOut[8].
- HazardStall = ValidOut & MemReadOut & (RtOut != 0) & ValidIn & ((RtOut == InstrIn[25:21]) | (RtOut == InstrIn[20:16])). Both source fields are compared regardless of instruction type (conservative).
- Per posedge, the first matching case applies:
  1. ExtStall: hold all registers; BubbleCount unchanged; Flush is ignored, and the branch unit must hold Flush until ExtStall drops.
  2. Flush: load a bubble (ValidOut=0, CtrlOut=0, all data and fields 0); BubbleCount does not increment.
  3. HazardStall: load a bubble; BubbleCount += 1, saturating at all-ones.
  4. Otherwise load: ValidOut=ValidIn; CtrlOut=ValidIn ? CtrlIn : 0; all other fields are captured.
- Latency: one cycle from IF/ID inputs to outputs.
- A bubble lasts exactly one cycle. On the next cycle the loaded instruction is a bubble, so HazardStall drops and the held IF/ID instruction is re-read. The register file has written on the intervening negedge, so the re-read data is correct.
- Immediate: ImmOut = {{16{InstrIn[15]}}, InstrIn[15:0]}.
- Register 0: the register file already returns 0; this block never forwards into register 0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: on a load, if WbRegWrite & WbRd != 0 & WbRd == rs field, RsDataOut = WbData instead of RsDataIn; the same rule applies independently to rt. This covers a write-back value not yet visible in the register file on that same edge (e.g. a read in the same half-cycle).
- Undefined: WbRegWrite, WbRd and WbData are ignored. Operands come from RsDataIn/RtDataIn only, relying on the register file's negedge write.

Decomposition:
- Shared package/include file (alongside the existing parameter include): control-bundle bit indices (CTRL_REGWRITE=9, CTRL_MEMREAD=8, ... ALUOP=3:0), CTRL_W=10, NOP control constant 10'b0, field slice constants.
- One sub-module, load_use_detect: purely combinational HazardStall equation, kept separate for reuse by a later forwarding unit.
- The pipeline register, priority logic and counter stay in id_ex_stage.

Test Plan:
- Reset: assert Reset mid-cycle with ValidOut=1 -> all outputs 0 immediately, BubbleCount=0.
- Normal load: InstrIn=0x8C220004 (lw $2,4($1)), RsDataIn=0x100, ValidIn=1 -> next edge RsOut=1, RtOut=2, ImmOut=0x4, CtrlOut equals CtrlIn, ValidOut=1.
- Load-use: the lw above in EX, then InstrIn=0x00430820 (add $1,$2,$3) -> HazardStall=1, next edge ValidOut=0, CtrlOut=0, BubbleCount=1; following edge loads the add with HazardStall=0.
- RtOut=0 case: a load targeting $0 followed by a use of $0 -> HazardStall=0, no bubble.
- ExtStall plus Flush together for 3 cycles -> outputs held unchanged; then drop ExtStall with Flush=1 -> bubble loaded, BubbleCount unchanged.
- With WB_BYPASS_EN: WbRegWrite=1, WbRd=2, WbData=0xDEAD, RtDataIn=0x1111, rt=2 -> RtDataOut=0xDEAD. Without the macro, the same stimulus gives RtDataOut=0x1111.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle bit
// positions, the NOP control word and instruction field slices.
package id_ex_stage_pkg;

    localparam int CTRL_W        = 10;
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMREAD  = 8;
    localparam int CTRL_MEMWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_ALUOP_HI = 3;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    localparam int REG_W  = 5;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector. Purely combinational so a later forwarding
// unit can reuse it. Both source fields of the ID instruction are compared
// regardless of format, which may stall unnecessarily but never misses.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic     valid_ex,
    input  logic     mem_read_ex,
    input  reg_idx_t rt_ex,
    input  logic     valid_id,
    input  reg_idx_t rs_id,
    input  reg_idx_t rt_id,
    output logic     stall
);

    // A load in EX whose destination (non-zero) is read by the ID instruction.
    assign stall = valid_ex & mem_read_ex & (rt_ex != '0) & valid_id &
                   ((rt_ex == rs_id) | (rt_ex == rt_id));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating bubble counter.
// Optional macro WB_BYPASS_EN: steer the write-back result into the rs/rt
// operand registers when WB targets the register being read.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       InstrIn,
    input  logic [DATA_W-1:0] PcPlus4In,
    input  logic              ValidIn,
    input  logic [DATA_W-1:0] RsDataIn,
    input  logic [DATA_W-1:0] RtDataIn,
    input  logic [CTRL_W-1:0] CtrlIn,
    input  logic              Flush,
    input  logic              ExtStall,
    input  logic              WbRegWrite,
    input  logic [4:0]        WbRd,
    input  logic [DATA_W-1:0] WbData,
    output logic              HazardStall,
    output logic              ValidOut,
    output logic [CTRL_W-1:0] CtrlOut,
    output logic [DATA_W-1:0] PcPlus4Out,
    output logic [DATA_W-1:0] RsDataOut,
    output logic [DATA_W-1:0] RtDataOut,
    output logic [DATA_W-1:0] ImmOut,
    output logic [4:0]        RsOut,
    output logic [4:0]        RtOut,
    output logic [4:0]        RdOut,
    output logic [4:0]        ShamtOut,
    output logic [CNT_W-1:0]  BubbleCount
);

    logic [DATA_W-1:0] rs_sel;
    logic [DATA_W-1:0] rt_sel;
    logic [DATA_W-1:0] imm_ext;
    reg_idx_t          rs_field;
    reg_idx_t          rt_field;

    assign rs_field = InstrIn[RS_HI:RS_LO];
    assign rt_field = InstrIn[RT_HI:RT_LO];
    assign imm_ext  = {{(DATA_W-IMM_W){InstrIn[IMM_HI]}}, InstrIn[IMM_HI:IMM_LO]};

    // Opcode is consumed by the decoder upstream, not here.
    wire unused_opcode = &{1'b0, InstrIn[31:26]};

`ifdef WB_BYPASS_EN
    // Prefer the write-back value when WB writes the register being read.
    always_comb begin
        rs_sel = RsDataIn;
        rt_sel = RtDataIn;
        if (WbRegWrite && (WbRd != '0) && (WbRd == rs_field))
            rs_sel = WbData;
        if (WbRegWrite && (WbRd != '0) && (WbRd == rt_field))
            rt_sel = WbData;
    end
`else
    // Register file writes on negedge, so its read data is already current.
    assign rs_sel = RsDataIn;
    assign rt_sel = RtDataIn;
    wire unused_wb = &{1'b0, WbRegWrite, WbRd, WbData};
`endif

    load_use_detect u_load_use_detect (
        .valid_ex    (ValidOut),
        .mem_read_ex (CtrlOut[CTRL_MEMREAD]),
        .rt_ex       (RtOut),
        .valid_id    (ValidIn),
        .rs_id       (rs_field),
        .rt_id       (rt_field),
        .stall       (HazardStall)
    );

    // Pipeline register: hold > flush > load-use bubble > normal load.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ValidOut    <= 1'b0;
            CtrlOut     <= CTRL_NOP;
            PcPlus4Out  <= '0;
            RsDataOut   <= '0;
            RtDataOut   <= '0;
            ImmOut      <= '0;
            RsOut       <= '0;
            RtOut       <= '0;
            RdOut       <= '0;
            ShamtOut    <= '0;
            BubbleCount <= '0;
        end else if (ExtStall) begin
            // Everything holds; a pending Flush is re-presented once the hold drops.
        end else if (Flush || HazardStall) begin
            ValidOut   <= 1'b0;
            CtrlOut    <= CTRL_NOP;
            PcPlus4Out <= '0;
            RsDataOut  <= '0;
            RtDataOut  <= '0;
            ImmOut     <= '0;
            RsOut      <= '0;
            RtOut      <= '0;
            RdOut      <= '0;
            ShamtOut   <= '0;
            // Only hazard bubbles are counted; flushes are branch cost, not stalls.
            if (!Flush && (BubbleCount != '1))
                BubbleCount <= BubbleCount + CNT_W'(1);
        end else begin
            ValidOut   <= ValidIn;
            CtrlOut    <= ValidIn ? CtrlIn : CTRL_NOP;
            PcPlus4Out <= PcPlus4In;
            RsDataOut  <= rs_sel;
            RtDataOut  <= rt_sel;
            ImmOut     <= imm_ext;
            RsOut      <= rs_field;
            RtOut      <= rt_field;
            RdOut      <= InstrIn[RD_HI:RD_LO];
            ShamtOut   <= InstrIn[SH_HI:SH_LO];
        end
    end

endmodule
